// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel coordinates, active/sync flags and animation strobes.
interface vga_timing_gen_if;
    logic [9:0] xx;
    logic [9:0] yy;
    logic       aactive;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;

    modport master (
        output xx, yy, aactive, hsync, vsync, line_start, frame_start, frame_cnt
    );

    modport slave (
        input xx, yy, aactive, hsync, vsync, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered active, sync and strobe flags.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic              Pclk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0]  HLast     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VLast     = 10'(V_TOTAL - 1);
    // 11-bit bounds so a window ending exactly at 1024 still compares correctly
    localparam logic [10:0] HAct      = 11'(H_ACTIVE);
    localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VAct      = 11'(V_ACTIVE);
    localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] xx_q, xx_d;
    logic [9:0] yy_q, yy_d;
    logic [7:0] cnt_q, cnt_d;
    logic       aactive_q, aactive_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       init_q;

    logic        x_wrap, y_wrap;
    logic [10:0] xe, ye;

    always_comb begin
        x_wrap = (xx_q == HLast);
        y_wrap = (yy_q == VLast);

        xx_d = x_wrap ? '0 : xx_q + 10'd1;
        yy_d = yy_q;
        if (x_wrap) begin
            yy_d = y_wrap ? '0 : yy_q + 10'd1;
        end

        // The wrap out of the reset state starts frame 0 and is not counted
        cnt_d = cnt_q;
        if (x_wrap && y_wrap && !init_q) begin
            cnt_d = cnt_q + 8'd1;
        end

        // Flags come from the next-state coordinates so they land with them
        xe            = {1'b0, xx_d};
        ye            = {1'b0, yy_d};
        aactive_d     = (xe < HAct) && (ye < VAct);
        hsync_d       = !((xe >= HSyncBeg) && (xe < HSyncEnd));
        vsync_d       = !((ye >= VSyncBeg) && (ye < VSyncEnd));
        line_start_d  = (xx_d == '0);
        frame_start_d = (xx_d == '0) && (yy_d == '0);
    end

    always_ff @(posedge Pclk) begin
        if (reset) begin
            xx_q          <= HLast;
            yy_q          <= VLast;
            cnt_q         <= '0;
            aactive_q     <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            init_q        <= 1'b1;
        end else begin
            xx_q          <= xx_d;
            yy_q          <= yy_d;
            cnt_q         <= cnt_d;
            aactive_q     <= aactive_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            init_q        <= 1'b0;
        end
    end

    assign vga.xx          = xx_q;
    assign vga.yy          = yy_q;
    assign vga.aactive     = aactive_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_cnt   = cnt_q;

endmodule
